// File: rtl/audio_dec_pkg.sv
// Shared constants and helpers for the multi-channel audio decimator.
package audio_dec_pkg;

  localparam logic MODE_HOLD = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_CHANNELS = 2;
  localparam int unsigned DEF_MAX_LOG2 = 12;

  // Requested exponents beyond the accumulator headroom saturate to the largest supported one.
  function automatic int unsigned clamp_log2(input int unsigned req, input int unsigned max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/audio_decimator_chan.sv
// One channel of the decimator: boxcar accumulator plus registered output sample.
module audio_decimator_chan
  import audio_dec_pkg::*;
#(
  parameter int unsigned DataW   = 16,
  parameter int unsigned MaxLog2 = 12,
  parameter int unsigned LogW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [LogW-1:0]  shift_i,
  input  logic [DataW-1:0] sample_i,
  output logic [DataW-1:0] sample_o
);

  localparam int unsigned AccW = DataW + MaxLog2;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] sum;
  logic [DataW-1:0]       out_q, out_d;

  always_comb begin
    // A block start never sees an old partial sum, so mode/factor switches carry no residue.
    sum   = (first_i ? '0 : acc_q) + {{MaxLog2{sample_i[DataW-1]}}, sample_i};
    acc_d = acc_q;
    out_d = out_q;
    if (advance_i) begin
      acc_d = (last_i || (mode_i == MODE_HOLD)) ? '0 : sum;
      if ((mode_i == MODE_HOLD) && first_i) begin
        out_d = sample_i;
      end
      if ((mode_i == MODE_AVG) && last_i) begin
        out_d = DataW'(sum >>> shift_i);
      end
    end else if (clear_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign sample_o = out_q;

endmodule

// File: rtl/audio_decimator_mc.sv
// Multi-channel power-of-two audio decimator; output keeps the input frame rate.
module audio_decimator_mc
  import audio_dec_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned MAX_LOG2 = DEF_MAX_LOG2,
  localparam int unsigned LogW    = $clog2(MAX_LOG2 + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic [CHANNELS*DATA_W-1:0] aud_in_i,
  input  logic [LogW-1:0]            factor_log2_i,
  input  logic                       mode_i,
  input  logic                       sync_clr_i,
  output logic                       out_valid_o,
  output logic [CHANNELS*DATA_W-1:0] aud_out_o,
  output logic                       dec_pulse_o
);

  logic [MAX_LOG2-1:0] cnt_q, cnt_d, cnt_cur, blk_mask;
  logic [LogW-1:0]     log2_q, log2_d, log2_req, log2_cur;
  logic                mode_q, mode_d, mode_cur;
  logic                first, last;
  logic                out_valid_d, out_valid_q;
  logic                dec_pulse_d, dec_pulse_q;

  always_comb begin
    first    = sync_clr_i || (cnt_q == '0);
    log2_req = LogW'(clamp_log2(32'(factor_log2_i), MAX_LOG2));
    // Factor and mode only take effect on the opening frame of a block.
    log2_cur = first ? log2_req : log2_q;
    mode_cur = first ? mode_i : mode_q;
    cnt_cur  = sync_clr_i ? '0 : cnt_q;
    for (int i = 0; i < int'(MAX_LOG2); i++) begin
      blk_mask[i] = (i < int'(log2_cur));
    end
    last = (cnt_cur == blk_mask);

    cnt_d  = cnt_q;
    log2_d = log2_q;
    mode_d = mode_q;
    if (in_valid_i) begin
      cnt_d = last ? '0 : cnt_cur + 1'b1;
      if (first) begin
        log2_d = log2_req;
        mode_d = mode_i;
      end
    end else if (sync_clr_i) begin
      cnt_d = '0;
    end

    out_valid_d = in_valid_i;
    dec_pulse_d = in_valid_i && ((mode_cur == MODE_AVG) ? last : first);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      log2_q      <= '0;
      mode_q      <= MODE_HOLD;
      out_valid_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      log2_q      <= log2_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      dec_pulse_q <= dec_pulse_d;
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : gen_chan
    audio_decimator_chan #(
      .DataW  (DATA_W),
      .MaxLog2(MAX_LOG2),
      .LogW   (LogW)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .advance_i(in_valid_i),
      .first_i  (first),
      .last_i   (last),
      .clear_i  (sync_clr_i),
      .mode_i   (mode_cur),
      .shift_i  (log2_cur),
      .sample_i (aud_in_i[g*DATA_W +: DATA_W]),
      .sample_o (aud_out_o[g*DATA_W +: DATA_W])
    );
  end

  assign out_valid_o = out_valid_q;
  assign dec_pulse_o = dec_pulse_q;

endmodule

// File: tb/tb_audio_decimator_mc.sv
// Directed bench for audio_decimator_mc with a frame-level reference model checked every cycle.
module tb_audio_decimator_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] aud_in = '0;
  logic [3:0]  factor = '0;
  logic        mode = 1'b0;
  logic        sync_clr = 1'b0;
  logic        out_valid;
  logic [31:0] aud_out;
  logic        dec_pulse;

  int n_chk = 0;
  int n_pass = 0;

  audio_decimator_mc #(
    .DATA_W  (16),
    .CHANNELS(2),
    .MAX_LOG2(12)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .aud_in_i     (aud_in),
    .factor_log2_i(factor),
    .mode_i       (mode),
    .sync_clr_i   (sync_clr),
    .out_valid_o  (out_valid),
    .aud_out_o    (aud_out),
    .dec_pulse_o  (dec_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: keeps the frames of the open block as a position and running sums.
  int                 m_pos = 0;
  int                 m_len = 1;
  logic               m_mode = 1'b0;
  longint             m_sum[2] = '{0, 0};
  logic signed [15:0] e_out[2] = '{16'sd0, 16'sd0};
  logic               e_valid = 1'b0;
  logic               e_pulse = 1'b0;

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pos = 0; m_len = 1; m_mode = 1'b0;
        m_sum = '{0, 0};
        e_out = '{16'sd0, 16'sd0};
        e_valid = 1'b0; e_pulse = 1'b0;
      end else begin
        e_valid = in_valid;
        e_pulse = 1'b0;
        if (sync_clr) begin
          m_pos = 0;
          m_sum = '{0, 0};
        end
        if (in_valid) begin
          if (m_pos == 0) begin
            m_len  = 1 << ((factor > 12) ? 12 : int'(factor));
            m_mode = mode;
            m_sum  = '{0, 0};
            if (!mode) begin
              e_out[0] = aud_in[15:0];
              e_out[1] = aud_in[31:16];
              e_pulse  = 1'b1;
            end
          end
          m_sum[0] += longint'($signed(aud_in[15:0]));
          m_sum[1] += longint'($signed(aud_in[31:16]));
          if (m_pos == m_len - 1) begin
            if (m_mode) begin
              e_out[0] = 16'(floor_div(m_sum[0], m_len));
              e_out[1] = 16'(floor_div(m_sum[1], m_len));
              e_pulse  = 1'b1;
            end
            m_pos = 0;
            m_sum = '{0, 0};
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_chk++;
      if ({aud_out, out_valid, dec_pulse} !== {e_out[1], e_out[0], e_valid, e_pulse}) begin
        $display("FAIL model t=%0t: got out=%h valid=%b pulse=%b, need out=%h valid=%b pulse=%b",
                 $time, aud_out, out_valid, dec_pulse, {e_out[1], e_out[0]}, e_valid, e_pulse);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, need %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic frame(input logic signed [15:0] s0, input logic signed [15:0] s1,
                       input logic clr);
    in_valid = 1'b1;
    sync_clr = clr;
    aud_in   = {s1, s0};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic longint ch(input int c);
    return longint'($signed(aud_out[c*16 +: 16]));
  endfunction

  int pulses;

  initial begin
    idle(3);
    chk("reset_out", longint'(aud_out), 0);
    chk("reset_valid", longint'(out_valid), 0);
    rst_n = 1'b1;
    idle(2);

    // Passthrough, one frame every 8 clocks
    factor = 4'd0; mode = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      frame(16'(i), 16'sd0, 1'b0);
      chk("pass_out", ch(0), i);
      chk("pass_pulse", longint'(dec_pulse), 1);
      chk("pass_valid", longint'(out_valid), 1);
      idle(7);
    end

    // Hold, factor 4
    factor = 4'd2;
    for (int i = 0; i < 5; i++) begin
      frame(16'(10 + i), 16'sd0, 1'b0);
      chk("hold_out", ch(0), (i == 4) ? 14 : 10);
      chk("hold_pulse", longint'(dec_pulse), (i == 0 || i == 4) ? 1 : 0);
    end
    sync_clr = 1'b1; idle(1); sync_clr = 1'b0;

    // Boxcar average, factor 4
    mode = 1'b1;
    frame(16'sd1, -16'sd1, 1'b0); chk("avg_held0", ch(0), 14); chk("avg_held1", ch(1), 0);
    frame(16'sd2, -16'sd2, 1'b0); chk("avg_held0", ch(0), 14);
    frame(16'sd3, -16'sd2, 1'b0); chk("avg_held0", ch(0), 14);
    chk("avg_nopulse", longint'(dec_pulse), 0);
    frame(16'sd5, -16'sd2, 1'b0);
    chk("avg_ch0", ch(0), 2); chk("avg_ch1", ch(1), -2);
    chk("avg_pulse", longint'(dec_pulse), 1);

    // Factor change mid-block only applies at the next boundary
    mode = 1'b0; factor = 4'd2;
    frame(16'sd20, 16'sd0, 1'b0);
    factor = 4'd1;
    frame(16'sd21, 16'sd0, 1'b0);
    frame(16'sd22, 16'sd0, 1'b0);
    frame(16'sd23, 16'sd0, 1'b0); chk("chg_blk_end", ch(0), 20);
    frame(16'sd24, 16'sd0, 1'b0); chk("chg_new_blk", ch(0), 24);
    frame(16'sd25, 16'sd0, 1'b0); chk("chg_held", ch(0), 24);
    frame(16'sd26, 16'sd0, 1'b0); chk("chg_two", ch(0), 26);
    chk("chg_pulse", longint'(dec_pulse), 1);
    frame(16'sd27, 16'sd0, 1'b0);

    // Oversized exponent saturates to 4096-frame blocks
    factor = 4'd15;
    pulses = 0;
    for (int k = 0; k <= 4096; k++) begin
      frame(16'(1000 + k), 16'sd0, 1'b0);
      if (dec_pulse) pulses++;
    end
    chk("clamp_pulses", longint'(pulses), 2);
    chk("clamp_out", ch(0), 5096);

    // Sync clear restarts an average block
    mode = 1'b1; factor = 4'd3;
    sync_clr = 1'b1; idle(1); sync_clr = 1'b0;
    for (int i = 0; i < 5; i++) frame(16'sd100, 16'sd0, 1'b0);
    chk("clr_pre", ch(0), 5096);
    frame(16'sd8, 16'sd0, 1'b1);
    chk("clr_frame", ch(0), 5096);
    for (int i = 0; i < 7; i++) frame(16'sd8, 16'sd0, 1'b0);
    chk("clr_avg", ch(0), 8);

    // Async reset mid-block, then back-to-back and gapped blocks
    factor = 4'd2;
    frame(16'sd50, 16'sd50, 1'b0);
    frame(16'sd50, 16'sd50, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_out", longint'(aud_out), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_pulse", longint'(dec_pulse), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int b = 0; b < 2; b++) begin
      frame(16'sd4, -16'sd3, 1'b0);  idle(b * 20);
      frame(16'sd8, -16'sd4, 1'b0);  idle(b * 20);
      frame(16'sd12, -16'sd4, 1'b0); idle(b * 20);
      chk("rst_blk_held", ch(0), (b == 0) ? 0 : 10);
      frame(16'sd16, -16'sd4, 1'b0);
      chk("rst_blk_ch0", ch(0), 10);
      chk("rst_blk_ch1", ch(1), -4);
      idle(b * 20);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
